// File: rtl/commu_pkg.sv
// Shared types and defaults for the RS-485 TDMA slot scheduler.
package commu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BUSY = 2'd2,
    ST_HOLD = 2'd3
  } slot_st_e;

  localparam int unsigned NS_PER_SEC   = 1000000000;
  localparam int unsigned NSLOT_DEF    = 64;
  localparam int unsigned SLOT_NS_DEF  = 15625000;
  localparam int unsigned GUARD_NS_DEF = 500000;

endpackage

// File: rtl/commu_slot_tmr.sv
// Slot timer: tracks the current TDMA slot within each UTC second
// and flags our own slot, the grant window and slot ends.
module commu_slot_tmr
  import commu_pkg::*;
#(
  parameter int unsigned NSLOT    = NSLOT_DEF,
  parameter int unsigned SLOT_NS  = SLOT_NS_DEF,
  parameter int unsigned GUARD_NS = GUARD_NS_DEF
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [31:0] utc_sec,
  input  logic [31:0] now_ns,
  input  logic [5:0]  own_slot,
  output logic [5:0]  slot_idx,
  output logic        own,
  output logic        open,
  output logic        slot_end
);

  localparam logic [5:0]  IDX_MAX = 6'(NSLOT - 1);
  localparam logic [31:0] SLOT_W  = 32'(SLOT_NS);
  localparam logic [31:0] GUARD_W = 32'(GUARD_NS);

  logic [31:0] sec_q;
  logic [31:0] slot_start;
  logic [31:0] next_bound;
  logic [31:0] open_at;
  logic        sec_edge;
  logic        adv;

  assign sec_edge = (utc_sec != sec_q);
  assign adv      = !sec_edge
                 && (now_ns >= next_bound)
                 && (slot_idx < IDX_MAX);
  assign slot_end = sec_edge || adv;

  assign open_at = slot_start + GUARD_W;
  assign own     = (slot_idx == own_slot);
  assign open    = own && (now_ns >= open_at);

  // sec_q loads the live second in reset so release is not an edge
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sec_q      <= utc_sec;
      slot_idx   <= '0;
      slot_start <= '0;
      next_bound <= SLOT_W;
    end else begin
      sec_q <= utc_sec;
      if (sec_edge) begin
        slot_idx   <= '0;
        slot_start <= '0;
        next_bound <= SLOT_W;
      end else if (adv) begin
        slot_idx   <= slot_idx + 6'd1;
        slot_start <= next_bound;
        next_bound <= next_bound + SLOT_W;
      end
    end
  end

endmodule

// File: rtl/commu_slot.sv
// TDMA slot scheduler: grants the bus in our own slot, aborts overruns,
// retries later. Channel alternation enabled by COMMU_SLOT_CHALT_EN.
module commu_slot
  import commu_pkg::*;
#(
  parameter int unsigned NSLOT    = NSLOT_DEF,
  parameter int unsigned SLOT_NS  = SLOT_NS_DEF,
  parameter int unsigned GUARD_NS = GUARD_NS_DEF
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [31:0] utc_sec,
  input  logic [31:0] now_ns,
  input  logic [7:0]  dev_id,
  input  logic [7:0]  cmd_retry,
  input  logic        slot_req,
  input  logic        slot_done,
  output logic        slot_rdy,
  output logic        slot_ch,
  output logic        slot_abort,
  output logic        slot_drop,
  output logic [5:0]  slot_idx,
  output logic [7:0]  retry_cnt
);

  localparam logic [5:0] IDX_MSK = 6'(NSLOT - 1);

  slot_st_e   state_q;
  slot_st_e   state_d;
  logic       rdy_d;
  logic       abort_d;
  logic       drop_d;
  logic [7:0] retry_d;
  logic       own;
  logic       open;
  logic       slot_end;
  logic [5:0] own_slot;
  logic       unused_id;

  assign own_slot  = dev_id[5:0] & IDX_MSK;
  assign unused_id = ^dev_id[7:6];

  commu_slot_tmr #(
    .NSLOT    (NSLOT),
    .SLOT_NS  (SLOT_NS),
    .GUARD_NS (GUARD_NS)
  ) u_tmr (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .utc_sec  (utc_sec),
    .now_ns   (now_ns),
    .own_slot (own_slot),
    .slot_idx (slot_idx),
    .own      (own),
    .open     (open),
    .slot_end (slot_end)
  );

  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b0;
    abort_d = 1'b0;
    drop_d  = 1'b0;
    retry_d = retry_cnt;
    unique case (state_q)
      ST_IDLE: begin
        if (slot_req) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!slot_req) begin
          state_d = ST_IDLE;
        end else if (open) begin
          state_d = ST_BUSY;
          rdy_d   = 1'b1;
        end
      end
      ST_BUSY: begin
        // done beats a coincident slot end
        if (slot_done) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else if (slot_end) begin
          abort_d = 1'b1;
          if (retry_cnt == cmd_retry) begin
            drop_d  = 1'b1;
            retry_d = '0;
            state_d = ST_IDLE;
          end else begin
            retry_d = retry_cnt + 8'd1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!own) state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slot_rdy   <= 1'b0;
      slot_abort <= 1'b0;
      slot_drop  <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      slot_rdy   <= rdy_d;
      slot_abort <= abort_d;
      slot_drop  <= drop_d;
      retry_cnt  <= retry_d;
    end
  end

`ifdef COMMU_SLOT_CHALT_EN
  logic ch_q;
  logic ch_clr;

  assign ch_clr = drop_d || (state_q == ST_BUSY && slot_done);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      ch_q <= 1'b0;
    end else if (ch_clr) begin
      ch_q <= 1'b0;
    end else if (abort_d) begin
      ch_q <= ~ch_q;
    end
  end

  assign slot_ch = ch_q;
`else
  assign slot_ch = 1'b0;
`endif

endmodule

// File: tb/tb_commu_slot.sv
// Scoreboard bench for commu_slot: expected pulses are queued as
// stimulus is driven and matched when the DUT emits them.
module tb_commu_slot;
  import commu_pkg::*;

`ifdef COMMU_SLOT_CHALT_EN
  localparam logic CHALT = 1'b1;
`else
  localparam logic CHALT = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [31:0] utc_sec;
  logic [31:0] now_ns;
  logic [7:0]  dev_id;
  logic [7:0]  cmd_retry;
  logic        slot_req;
  logic        slot_done;
  logic        slot_rdy;
  logic        slot_ch;
  logic        slot_abort;
  logic        slot_drop;
  logic [5:0]  slot_idx;
  logic [7:0]  retry_cnt;

  typedef struct packed {
    int unsigned cyc;
    logic [11:0] evt;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  commu_slot dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .utc_sec    (utc_sec),
    .now_ns     (now_ns),
    .dev_id     (dev_id),
    .cmd_retry  (cmd_retry),
    .slot_req   (slot_req),
    .slot_done  (slot_done),
    .slot_rdy   (slot_rdy),
    .slot_ch    (slot_ch),
    .slot_abort (slot_abort),
    .slot_drop  (slot_drop),
    .slot_idx   (slot_idx),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic drive(logic [31:0] ns);
    now_ns = ns;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_evt(int unsigned dly, logic r, logic a,
                          logic d, logic c, logic [7:0] rc);
    exp_t x;
    x.cyc = cyc + dly;
    x.evt = {r, a, d, c, rc};
    sb.push_back(x);
  endtask

  task automatic to_slot3();
    repeat (4) drive(32'd46875000);
    chk("idx_slot3", 64'(slot_idx), 64'd3);
  endtask

  always @(negedge clk_sys) begin
    if (slot_rdy || slot_abort || slot_drop) begin
      if (sb.size() == 0) begin
        chk("sb_unexp", 64'({slot_rdy, slot_abort, slot_drop}), 64'd0);
      end else begin
        e_mon = sb.pop_front();
        chk("sb_cyc", 64'(cyc), 64'(e_mon.cyc));
        chk("sb_evt",
            64'({slot_rdy, slot_abort, slot_drop, slot_ch, retry_cnt}),
            64'(e_mon.evt));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    utc_sec   = 32'd100;
    now_ns    = 32'd0;
    dev_id    = 8'd3;
    cmd_retry = 8'd2;
    slot_req  = 1'b0;
    slot_done = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;

    chk("rst_rdy",   64'(slot_rdy), 64'd0);
    chk("rst_ch",    64'(slot_ch), 64'd0);
    chk("rst_abort", 64'(slot_abort), 64'd0);
    chk("rst_drop",  64'(slot_drop), 64'd0);
    chk("rst_idx",   64'(slot_idx), 64'd0);
    chk("rst_retry", 64'(retry_cnt), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("rst_bound", 64'(dut.u_tmr.next_bound), 64'd15625000);

    // grant exactly at guard end
    slot_req = 1'b1;
    drive(32'd0);
    to_slot3();
    for (int k = 0; k <= 14; k++) begin
      if (k == 10) push_evt(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      drive(32'd46875000 + 32'(k) * 32'd50000);
    end
    chk("grant_busy", 64'(dut.state_q), 64'(ST_BUSY));

    // normal completion
    slot_done = 1'b1;
    slot_req  = 1'b0;
    drive(32'd50000000);
    slot_done = 1'b0;
    chk("done_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("done_retry", 64'(retry_cnt), 64'd0);

    // overrun with retries left
    slot_req = 1'b1;
    push_evt(2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (3) drive(32'd50000000);
    push_evt(1, 1'b0, 1'b1, 1'b0, CHALT, 8'd1);
    drive(32'd62500000);
    repeat (4) drive(32'd62500000);
    chk("ovr_state", 64'(dut.state_q), 64'(ST_WAIT));
    chk("ovr_retry", 64'(retry_cnt), 64'd1);
    chk("ovr_idx",   64'(slot_idx), 64'd4);

    // retry in next second's slot 3
    utc_sec = 32'd101;
    drive(32'd0);
    to_slot3();
    push_evt(1, 1'b1, 1'b0, 1'b0, CHALT, 8'd1);
    drive(32'd47375000);
    repeat (2) drive(32'd50000000);

    // done coincident with slot end
    slot_done = 1'b1;
    slot_req  = 1'b0;
    drive(32'd62500000);
    slot_done = 1'b0;
    chk("coinc_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("coinc_retry", 64'(retry_cnt), 64'd0);
    chk("coinc_ch",    64'(slot_ch), 64'd0);

    // exhaustion with no retries allowed
    cmd_retry = 8'd0;
    utc_sec   = 32'd102;
    slot_req  = 1'b1;
    drive(32'd0);
    to_slot3();
    push_evt(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    drive(32'd47375000);
    drive(32'd50000000);
    push_evt(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    drive(32'd62500000);
    chk("exh_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("exh_retry", 64'(retry_cnt), 64'd0);
    slot_req = 1'b0;
    drive(32'd62500000);

    // second wrap while busy in slot 63
    dev_id    = 8'hFF;
    cmd_retry = 8'd2;
    repeat (70) drive(32'd999999999);
    chk("sat_idx", 64'(slot_idx), 64'd63);
    slot_req = 1'b1;
    push_evt(2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (4) drive(32'd999999999);
    utc_sec = 32'd103;
    push_evt(1, 1'b0, 1'b1, 1'b0, CHALT, 8'd1);
    drive(32'd0);
    chk("wrap_idx", 64'(slot_idx), 64'd0);
    slot_req = 1'b0;
    repeat (2) drive(32'd0);
    chk("wrap_state", 64'(dut.state_q), 64'(ST_IDLE));

    // catch-up one slot per cycle
    dev_id = 8'd3;
    for (int i = 1; i <= 6; i++) begin
      drive(32'd100000000);
      chk($sformatf("catch_%0d", i), 64'(slot_idx), 64'(i));
    end
    repeat (2) drive(32'd100000000);
    chk("catch_hold", 64'(slot_idx), 64'd6);

    // reset while busy
    utc_sec  = 32'd104;
    slot_req = 1'b1;
    drive(32'd0);
    to_slot3();
    push_evt(1, 1'b1, 1'b0, 1'b0, CHALT, 8'd1);
    drive(32'd47375000);
    drive(32'd50000000);
    chk("prerst_state", 64'(dut.state_q), 64'(ST_BUSY));
    rst_n    = 1'b0;
    slot_req = 1'b0;
    drive(32'd50000000);
    rst_n = 1'b1;
    chk("mrst_out",
        64'({slot_rdy, slot_ch, slot_abort, slot_drop, slot_idx,
             retry_cnt}), 64'd0);
    chk("mrst_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("mrst_bound", 64'(dut.u_tmr.next_bound), 64'd15625000);
    chk("mrst_start", 64'(dut.u_tmr.slot_start), 64'd0);
    repeat (3) drive(32'd50000000);

    chk("sb_left", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
